// File: rtl/reg_file_sb.sv
// Register file with per-entry pending scoreboard and sequenced bulk clear.
// Read ports return data plus a ready bit that drops while an entry has an outstanding producer.

module reg_file_sb_rdport #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int ZERO_REG   = 1,
  parameter int BYPASS     = 1
) (
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic                  in_rng_i,
  input  logic [DATA_WIDTH-1:0] word_i,
  input  logic                  pend_i,
  input  logic                  wr_eff_i,
  input  logic [ADDR_WIDTH-1:0] wr_addr_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  ready_o
);
  always_comb begin
    data_o  = word_i;
    ready_o = ~pend_i;
    if (!in_rng_i || ((ZERO_REG != 0) && (addr_i == '0))) begin
      data_o  = '0;
      ready_o = 1'b1;
    end else if ((BYPASS != 0) && wr_eff_i && (wr_addr_i == addr_i)) begin
      data_o  = wr_data_i;
      ready_o = 1'b1;
    end
  end
endmodule

module reg_file_sb #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 32,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int NUM_RD     = 2,
  parameter int ZERO_REG   = 1,
  parameter int BYPASS     = 1
) (
  input  logic                         clk,
  input  logic                         arst_n,
  input  logic                         wr_en,
  input  logic [ADDR_WIDTH-1:0]        wr_addr,
  input  logic [DATA_WIDTH-1:0]        wr_data,
  input  logic                         rsv_en,
  input  logic [ADDR_WIDTH-1:0]        rsv_addr,
  input  logic [NUM_RD*ADDR_WIDTH-1:0] rd_addr,
  output logic [NUM_RD*DATA_WIDTH-1:0] rd_data,
  output logic [NUM_RD-1:0]            rd_ready,
  input  logic                         clr_start,
  output logic                         clr_busy,
  output logic                         clr_done
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_CLEAR = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  localparam logic [ADDR_WIDTH:0]   DEPTH_W  = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(DEPTH - 1);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0]      pend_q, pend_d;
  logic [1:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] idx_q, idx_d;
  logic                  wr_eff, rsv_eff;

  assign clr_busy = (state_q != S_IDLE);
  assign clr_done = (state_q == S_DONE);

  // Strobes are dropped (not queued) for the whole busy window, DONE included.
  assign wr_eff  = wr_en && ({1'b0, wr_addr} < DEPTH_W) && !clr_busy &&
                   !((ZERO_REG != 0) && (wr_addr == '0));
  assign rsv_eff = rsv_en && ({1'b0, rsv_addr} < DEPTH_W) && !clr_busy &&
                   !((ZERO_REG != 0) && (rsv_addr == '0));

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      S_IDLE: if (clr_start) begin
        state_d = S_CLEAR;
        idx_d   = '0;
      end
      S_CLEAR: begin
        idx_d = idx_q + ADDR_WIDTH'(1);
        if (idx_q == LAST_IDX) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Reserve is applied last so a same-cycle reserve+write leaves the entry pending.
  always_comb begin
    pend_d = pend_q;
    if (state_q == S_CLEAR) pend_d[idx_q]    = 1'b0;
    if (wr_eff)             pend_d[wr_addr]  = 1'b0;
    if (rsv_eff)            pend_d[rsv_addr] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!arst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      pend_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      pend_q  <= pend_d;
      if (wr_eff)             mem_q[wr_addr] <= wr_data;
      if (state_q == S_CLEAR) mem_q[idx_q]   <= '0;
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_WIDTH-1:0] a;
    logic                  in_rng;
    assign a      = rd_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
    assign in_rng = ({1'b0, a} < DEPTH_W);

    reg_file_sb_rdport #(
      .DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH),
      .ZERO_REG(ZERO_REG), .BYPASS(BYPASS)
    ) u_rd (
      .addr_i   (a),
      .in_rng_i (in_rng),
      .word_i   (mem_q[a]),
      .pend_i   (pend_q[a]),
      .wr_eff_i (wr_eff),
      .wr_addr_i(wr_addr),
      .wr_data_i(wr_data),
      .data_o   (rd_data[k*DATA_WIDTH +: DATA_WIDTH]),
      .ready_o  (rd_ready[k])
    );
  end
endmodule

// File: tb/tb_reg_file_sb.sv
// Directed + random bench for reg_file_sb against an array-based reference model.

module tb_reg_file_sb;
  logic        clk = 1'b0;
  logic        arst_n;
  logic        wr_en, rsv_en, clr_start;
  logic [4:0]  wr_addr, rsv_addr;
  logic [31:0] wr_data;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic [1:0]  rd_ready;
  logic        clr_busy, clr_done;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] m_mem [32];
  bit          m_pend [32];
  logic [31:0] old [32];

  reg_file_sb dut (
    .clk(clk), .arst_n(arst_n),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_ready(rd_ready),
    .clr_start(clr_start), .clr_busy(clr_busy), .clr_done(clr_done)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  task automatic set_rd(input int a0, input int a1);
    rd_addr[4:0] = a0[4:0];
    rd_addr[9:5] = a1[4:0];
  endtask

  task automatic idle();
    wr_en = 1'b0; rsv_en = 1'b0; clr_start = 1'b0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin m_mem[i] = '0; m_pend[i] = 1'b0; end
  endtask

  // Expected read result while the clear engine is idle.
  task automatic exp_rd(input logic [4:0] a, output logic [31:0] d, output logic r);
    if (a == 0) begin d = '0; r = 1'b1; end
    else if (wr_en && wr_addr == a) begin d = wr_data; r = 1'b1; end
    else begin d = m_mem[a]; r = !m_pend[a]; end
  endtask

  task automatic check_reads(input string tag);
    logic [31:0] d; logic r;
    for (int k = 0; k < 2; k++) begin
      exp_rd(rd_addr[k*5 +: 5], d, r);
      chk({tag, "_data"}, rd_data[k*32 +: 32], d);
      chk({tag, "_rdy"}, {31'b0, rd_ready[k]}, {31'b0, r});
    end
  endtask

  task automatic tick();
    if (wr_en && wr_addr != 0) begin m_mem[wr_addr] = wr_data; m_pend[wr_addr] = 1'b0; end
    if (rsv_en && rsv_addr != 0) m_pend[rsv_addr] = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic sweep_zero(input string tag);
    for (int a = 0; a < 32; a++) begin
      set_rd(a, 31 - a);
      #4;
      chk({tag, "_d0"}, rd_data[31:0], 32'h0);
      chk({tag, "_d1"}, rd_data[63:32], 32'h0);
      chk({tag, "_rdy"}, {30'b0, rd_ready}, 32'h3);
      chk({tag, "_done"}, {31'b0, clr_done}, 32'h0);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    int busy_n, done_n, done_j;
    arst_n = 1'b0; idle();
    wr_addr = '0; wr_data = '0; rsv_addr = '0; rd_addr = '0;
    repeat (2) @(posedge clk);
    #1; arst_n = 1'b1; model_reset();

    // Reset state
    #4;
    chk("rst_busy", {31'b0, clr_busy}, 32'h0);
    chk("rst_done", {31'b0, clr_done}, 32'h0);
    @(posedge clk); #1;
    sweep_zero("rst");

    // Write r5, read on both ports
    wr_en = 1'b1; wr_addr = 5; wr_data = 32'hDEADBEEF; set_rd(5, 5);
    #4; chk("r5_byp", rd_data[31:0], 32'hDEADBEEF); tick();
    wr_en = 1'b0;
    #4;
    chk("r5_p0", rd_data[31:0], 32'hDEADBEEF);
    chk("r5_p1", rd_data[63:32], 32'hDEADBEEF);
    check_reads("r5"); tick();

    // Write to r0 is discarded
    wr_en = 1'b1; wr_addr = 0; wr_data = 32'hFFFFFFFF; set_rd(0, 0);
    #4; chk("r0_byp", rd_data[31:0], 32'h0); tick();
    wr_en = 1'b0;
    #4; chk("r0_after", rd_data[63:32], 32'h0); tick();

    // Reserve r7, then produce it
    rsv_en = 1'b1; rsv_addr = 7; set_rd(7, 7);
    #4; chk("r7_rsv_same", {31'b0, rd_ready[0]}, 32'h1); tick();
    rsv_en = 1'b0;
    #4; chk("r7_pend", {31'b0, rd_ready[0]}, 32'h0); check_reads("r7p"); tick();
    wr_en = 1'b1; wr_addr = 7; wr_data = 32'h1234;
    #4;
    chk("r7_byp_data", rd_data[31:0], 32'h1234);
    chk("r7_byp_rdy", {31'b0, rd_ready[0]}, 32'h1);
    tick();
    wr_en = 1'b0;
    #4;
    chk("r7_stored_rdy", {31'b0, rd_ready[1]}, 32'h1);
    chk("r7_stored_data", rd_data[63:32], 32'h1234);
    tick();

    // Reserve + write r9 in the same cycle
    wr_en = 1'b1; wr_addr = 9; wr_data = 32'h99; rsv_en = 1'b1; rsv_addr = 9; set_rd(9, 3);
    #4; tick();
    idle(); wr_data = 32'hFFFF0000;
    #4;
    chk("r9_data", rd_data[31:0], 32'h99);
    chk("r9_pend", {31'b0, rd_ready[0]}, 32'h0);
    check_reads("r9"); tick();

    // Fill, leave some entries pending, then bulk clear
    for (int a = 1; a < 32; a++) begin
      wr_en = 1'b1; wr_addr = 5'(a); wr_data = $urandom | 32'h1; tick();
    end
    idle();
    rsv_en = 1'b1; rsv_addr = 2; tick();
    rsv_addr = 4; tick();
    idle();
    for (int i = 0; i < 32; i++) old[i] = m_mem[i];
    clr_start = 1'b1; tick();
    busy_n = 0; done_n = 0; done_j = -1;
    for (int j = 0; j < 100; j++) begin
      set_rd(j < 32 ? j : 0, j > 0 ? j - 1 : 0);
      wr_en = (j == 3); wr_addr = 31; wr_data = 32'hA5A5A5A5;
      clr_start = (j == 5);
      if (j == 3) set_rd(3, 31);
      #4;
      if (!clr_busy) break;
      busy_n++;
      if (clr_done) begin done_n++; done_j = j; end
      if (j < 32) chk("clr_old", rd_data[31:0], old[j]);
      if (j == 3) chk("clr_wr_drop", rd_data[63:32], old[31]);
      else if (j > 0) chk("clr_zeroed", rd_data[63:32], 32'h0);
      @(posedge clk); #1;
    end
    idle();
    chk("clr_busy_cycles", busy_n, 33);
    chk("clr_done_pulses", done_n, 1);
    chk("clr_done_cycle", done_j, 32);
    model_reset();
    @(posedge clk); #1;
    sweep_zero("clr");

    // Reset in the middle of a clear
    for (int a = 1; a < 32; a++) begin
      wr_en = 1'b1; wr_addr = 5'(a); wr_data = $urandom | 32'h1; tick();
    end
    idle();
    clr_start = 1'b1; tick();
    clr_start = 1'b0;
    repeat (10) begin @(posedge clk); #1; end
    arst_n = 1'b0;
    @(posedge clk); #1;
    arst_n = 1'b1; model_reset();
    #4;
    chk("abort_busy", {31'b0, clr_busy}, 32'h0);
    chk("abort_done", {31'b0, clr_done}, 32'h0);
    @(posedge clk); #1;
    sweep_zero("abort");

    // Random traffic against the model
    for (int n = 0; n < 300; n++) begin
      wr_en = 1'($urandom_range(0, 1)); wr_addr = 5'($urandom_range(0, 15)); wr_data = $urandom;
      rsv_en = ($urandom_range(0, 3) == 0); rsv_addr = 5'($urandom_range(0, 15));
      set_rd(($urandom_range(0, 3) == 0) ? int'(wr_addr) : int'($urandom_range(0, 15)),
             int'($urandom_range(0, 31)));
      #4; check_reads("rand"); tick();
    end
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
